// File: rtl/dmem_access_unit_if.sv
// Core-side load/store request/response and word-wide data-memory bus of dmem_access_unit.
interface dmem_access_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_rd_en;
    logic              i_wr_en;
    logic [2:0]        i_funct3;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_wdata;
    logic              o_rsp_valid;
    logic [31:0]       o_rdata;
    logic              o_fault;
    logic              o_busy;
    logic              o_mem_req;
    logic              o_mem_wen;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [3:0]        o_mem_wmask;
    logic [31:0]       o_mem_wdata;
    logic              i_mem_ready;
    logic              i_mem_rvalid;
    logic [31:0]       i_mem_rdata;

    modport slave (
        input  i_req_valid, i_rd_en, i_wr_en, i_funct3, i_addr, i_wdata,
               i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_req_ready, o_rsp_valid, o_rdata, o_fault, o_busy,
               o_mem_req, o_mem_wen, o_mem_addr, o_mem_wmask, o_mem_wdata
    );

    modport master (
        output i_req_valid, i_rd_en, i_wr_en, i_funct3, i_addr, i_wdata,
               i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_req_ready, o_rsp_valid, o_rdata, o_fault, o_busy,
               o_mem_req, o_mem_wen, o_mem_addr, o_mem_wmask, o_mem_wdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Load/store unit: drives a word-wide data memory with byte masks, optionally splitting
// misaligned accesses into two word transactions, and returns extended load data.
module dmem_access_unit #(
    parameter int unsigned ADDR_W    = 32,
    parameter bit          SPLIT_MIS = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    dmem_access_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ACC0, WAIT0, ACC1, WAIT1, RESP} state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        split_q;
    logic [31:0] r0_q;
    logic [31:0] wdata_hi_q;
    logic [3:0]  wmask_hi_q;

    logic [1:0]        req_off;
    logic [1:0]        req_size;
    logic [3:0]        byte_mask;
    logic [7:0]        lane_mask;
    logic [63:0]       lane_data;
    logic              req_split;
    logic              misaligned;
    logic              illegal;
    logic [ADDR_W-1:0] word0_addr;

    // Request decode; only consumed while IDLE.
    always_comb begin
        req_off  = bus.i_addr[1:0];
        req_size = bus.i_funct3[1:0];
        case (req_size)
            2'b00:   byte_mask = 4'b0001;
            2'b01:   byte_mask = 4'b0011;
            default: byte_mask = 4'b1111;
        endcase
        lane_mask  = 8'(byte_mask) << req_off;
        lane_data  = 64'(bus.i_wdata) << {req_off, 3'b000};
        req_split  = |lane_mask[7:4];
        misaligned = ((req_size == 2'b01) && req_off[0])
                  || ((req_size == 2'b10) && (req_off != 2'b00));
        illegal    = (bus.i_rd_en == bus.i_wr_en)
                  || (req_size == 2'b11)
                  || (bus.i_rd_en && bus.i_funct3[2] && (req_size == 2'b10))
                  || (bus.i_wr_en && bus.i_funct3[2])
                  || (misaligned && !SPLIT_MIS);
        word0_addr = {bus.i_addr[ADDR_W-1:2], 2'b00};
    end

    // Pick the addressed bytes out of the two-word window and extend them.
    function automatic logic [31:0] load_ext(input logic [63:0] pair,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
        logic [63:0] sh;
        logic [31:0] res;
        sh = pair >> {off, 3'b000};
        case (f3[1:0])
            2'b00:   res = {{24{sh[7]  & ~f3[2]}}, sh[7:0]};
            2'b01:   res = {{16{sh[15] & ~f3[2]}}, sh[15:0]};
            default: res = sh[31:0];
        endcase
        return res;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            off_q           <= '0;
            f3_q            <= '0;
            split_q         <= 1'b0;
            r0_q            <= '0;
            wdata_hi_q      <= '0;
            wmask_hi_q      <= '0;
            bus.o_req_ready <= 1'b1;
            bus.o_busy      <= 1'b0;
            bus.o_rsp_valid <= 1'b0;
            bus.o_rdata     <= '0;
            bus.o_fault     <= 1'b0;
            bus.o_mem_req   <= 1'b0;
            bus.o_mem_wen   <= 1'b0;
            bus.o_mem_addr  <= '0;
            bus.o_mem_wmask <= '0;
            bus.o_mem_wdata <= '0;
        end else begin
            bus.o_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_req_valid) begin
                        off_q           <= req_off;
                        f3_q            <= bus.i_funct3;
                        split_q         <= req_split;
                        wdata_hi_q      <= bus.i_wr_en ? lane_data[63:32] : 32'h0;
                        wmask_hi_q      <= bus.i_wr_en ? lane_mask[7:4] : 4'b0000;
                        bus.o_req_ready <= 1'b0;
                        bus.o_busy      <= 1'b1;
                        if (illegal) begin
                            state           <= RESP;
                            bus.o_rsp_valid <= 1'b1;
                            bus.o_fault     <= 1'b1;
                            bus.o_rdata     <= '0;
                        end else begin
                            state           <= ACC0;
                            bus.o_mem_req   <= 1'b1;
                            bus.o_mem_wen   <= bus.i_wr_en;
                            bus.o_mem_addr  <= word0_addr;
                            bus.o_mem_wmask <= bus.i_wr_en ? lane_mask[3:0] : 4'b0000;
                            bus.o_mem_wdata <= bus.i_wr_en ? lane_data[31:0] : 32'h0;
                        end
                    end
                end
                ACC0: begin
                    if (bus.i_mem_ready) begin
                        bus.o_mem_req <= 1'b0;
                        if (!bus.o_mem_wen) begin
                            state <= WAIT0;
                        end else if (split_q) begin
                            state           <= ACC1;
                            bus.o_mem_req   <= 1'b1;
                            bus.o_mem_addr  <= bus.o_mem_addr + ADDR_W'(4);
                            bus.o_mem_wmask <= wmask_hi_q;
                            bus.o_mem_wdata <= wdata_hi_q;
                        end else begin
                            state           <= RESP;
                            bus.o_rsp_valid <= 1'b1;
                            bus.o_fault     <= 1'b0;
                            bus.o_rdata     <= '0;
                        end
                    end
                end
                WAIT0: begin
                    if (bus.i_mem_rvalid) begin
                        r0_q <= bus.i_mem_rdata;
                        if (split_q) begin
                            state           <= ACC1;
                            bus.o_mem_req   <= 1'b1;
                            bus.o_mem_addr  <= bus.o_mem_addr + ADDR_W'(4);
                            bus.o_mem_wmask <= wmask_hi_q;
                            bus.o_mem_wdata <= wdata_hi_q;
                        end else begin
                            state           <= RESP;
                            bus.o_rsp_valid <= 1'b1;
                            bus.o_fault     <= 1'b0;
                            bus.o_rdata     <= load_ext({32'h0, bus.i_mem_rdata}, off_q, f3_q);
                        end
                    end
                end
                ACC1: begin
                    if (bus.i_mem_ready) begin
                        bus.o_mem_req <= 1'b0;
                        if (bus.o_mem_wen) begin
                            state           <= RESP;
                            bus.o_rsp_valid <= 1'b1;
                            bus.o_fault     <= 1'b0;
                            bus.o_rdata     <= '0;
                        end else begin
                            state <= WAIT1;
                        end
                    end
                end
                WAIT1: begin
                    if (bus.i_mem_rvalid) begin
                        state           <= RESP;
                        bus.o_rsp_valid <= 1'b1;
                        bus.o_fault     <= 1'b0;
                        bus.o_rdata     <= load_ext({bus.i_mem_rdata, r0_q}, off_q, f3_q);
                    end
                end
                RESP: begin
                    state           <= IDLE;
                    bus.o_req_ready <= 1'b1;
                    bus.o_busy      <= 1'b0;
                end
                default: begin
                    state           <= IDLE;
                    bus.o_req_ready <= 1'b1;
                    bus.o_busy      <= 1'b0;
                    bus.o_mem_req   <= 1'b0;
                end
            endcase
        end
    end
endmodule
